// File: rtl/ifetch_bus_if_pkg.sv
// Shared definitions for the instruction-fetch bus interface: reset level,
// bus widths, FSM state encodings and small helpers.
package ifetch_bus_if_pkg;

   localparam logic RST_ENABLE  = 1'b1;
   localparam int   INST_ADDR_W = 32;
   localparam int   INST_W      = 32;

   localparam logic [INST_W-1:0] ZERO_WORD = '0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_t;

   // Fetch addresses are word aligned; anything else is reported downstream.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_bus_if_buf.sv
// One-entry tagged instruction buffer: fill, invalidate, hit compare and
// data/error output muxing for the fetch interface.
module ifetch_buf
   import ifetch_bus_if_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_W,
   parameter int DATA_W = INST_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inval,
   input  logic              fill,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [DATA_W-1:0] fill_data,
   input  logic              fill_err,
   input  logic [ADDR_W-1:0] pc,
   input  logic              flush,
   output logic              hit,
   output logic [DATA_W-1:0] data,
   output logic              err
);

   logic              buf_valid;
   logic [ADDR_W-1:0] buf_addr;
   logic [DATA_W-1:0] buf_data;
   logic              buf_err;

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
         buf_err   <= 1'b0;
      end else if (inval) begin
         buf_valid <= 1'b0;
      end else if (fill) begin
         buf_valid <= 1'b1;
         buf_addr  <= fill_addr;
         buf_data  <= fill_data;
         buf_err   <= fill_err;
      end
   end

   // A flush hides the entry in the same cycle it is being invalidated.
   assign hit  = buf_valid & (buf_addr == pc) & ~flush;
   assign data = hit ? buf_data : '0;
   assign err  = hit & buf_err;

endmodule

// File: rtl/ifetch_bus_if.sv
// Instruction-fetch bus interface: req/ack read of the fetch address into a
// one-entry buffer, with flush handling. IFETCH_TIMEOUT_EN adds a REQ timeout.
module ifetch_bus_if
   import ifetch_bus_if_pkg::*;
#(
   parameter int ADDR_W         = INST_ADDR_W,
   parameter int DATA_W         = INST_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              flush_i,
   output logic [DATA_W-1:0] pc_data_o,
   output logic              pc_ready_o,
   output logic              fetch_err_o,
   output logic              bus_req_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   input  logic              bus_ack_i,
   input  logic [DATA_W-1:0] bus_data_i,
   input  logic              bus_err_i
);

   // state   | meaning
   // ST_IDLE | no bus read outstanding; buffer answers the PC stage
   // ST_REQ  | bus_req_o held at req_addr until ack (or timeout)

   fetch_state_t      state;
   logic              stale;
   logic [ADDR_W-1:0] req_addr;

   logic              hit;
   logic              misaligned;
   logic [DATA_W-1:0] hit_data;
   logic              hit_err;

   logic              ack_fill;
   logic              timeout;
   logic              fill;
   logic [DATA_W-1:0] fill_data;
   logic              fill_err;

   assign misaligned = is_misaligned(pc_i[1:0]);

`ifdef IFETCH_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [CNT_W-1:0] to_cnt;

   assign timeout = (state == ST_REQ) & ~bus_ack_i &
                    (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout            = 1'b0;
`endif

   // Stale or flushed completions never reach the buffer.
   assign ack_fill  = (state == ST_REQ) & bus_ack_i & ~stale & ~flush_i;
   assign fill      = ack_fill | (timeout & ~stale & ~flush_i);
   assign fill_data = ack_fill ? bus_data_i : DATA_W'(ZERO_WORD);
   assign fill_err  = ack_fill ? bus_err_i : 1'b1;

   ifetch_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .inval     (flush_i),
      .fill      (fill),
      .fill_addr (req_addr),
      .fill_data (fill_data),
      .fill_err  (fill_err),
      .pc        (pc_i),
      .flush     (flush_i),
      .hit       (hit),
      .data      (hit_data),
      .err       (hit_err)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state     <= ST_IDLE;
         bus_req_o <= 1'b0;
         req_addr  <= '0;
         stale     <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
         to_cnt    <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (~hit & ~misaligned & ~flush_i) begin
                  state     <= ST_REQ;
                  bus_req_o <= 1'b1;
                  req_addr  <= pc_i;
               end
            end
            ST_REQ: begin
               if (bus_ack_i | timeout) begin
                  state     <= ST_IDLE;
                  bus_req_o <= 1'b0;
                  stale     <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
                  to_cnt    <= '0;
`endif
               end else begin
                  if (flush_i) begin
                     stale <= 1'b1;
                  end
`ifdef IFETCH_TIMEOUT_EN
                  to_cnt <= to_cnt + 1'b1;
`endif
               end
            end
            default: begin
               state     <= ST_IDLE;
               bus_req_o <= 1'b0;
            end
         endcase
      end
   end

   assign bus_addr_o  = req_addr;
   assign pc_ready_o  = hit | misaligned;
   assign pc_data_o   = misaligned ? DATA_W'(ZERO_WORD) : hit_data;
   assign fetch_err_o = ~misaligned & hit_err;

endmodule
